l2_ram_slave_bridge: RTL

L2_RAM_SLAVE_BRIDGE -- requirements
Module: l2_ram_slave_bridge

---
 rtl/l2_ram_slave_bridge.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/l2_ram_slave_bridge.sv
`default_nettype none
// ============================================================================
// Module      : l2_ram_slave_bridge
// Description : Bridges a req/gnt peripheral slave port onto a single-port
//               word-addressed SRAM. At most one transaction is in flight:
//               a request is granted in IDLE, the SRAM is strobed in that
//               same cycle, and the response is returned one cycle later.
//               Write statistics (count, XOR of data) and a sticky error
//               flag are kept alongside.
// Ports       : clk_i, rst_i                 clock, sync active-high reset
//               per_slave_*_i / per_slave_gnt_o  peripheral request channel
//               per_slave_r_*_o              peripheral response channel
//               mem_*                        SRAM port (rdata 1 cycle after req)
//               stats_clr_i, wr_count_o,
//               wr_xor_o, err_o              statistics and error status
// Revision    : 1.0 - initial release
// ============================================================================
module l2_ram_slave_bridge #(
   parameter int                         ADDR_WIDTH     = 12,
   parameter int                         PER_ID_WIDTH   = 1,
   parameter int                         PER_ADDR_WIDTH = 32,
   parameter logic [PER_ADDR_WIDTH-1:0]  BASE_ADDR      = 32'h1C000000
) (
   input  logic                      clk_i,
   input  logic                      rst_i,

   input  logic                      per_slave_req_i,
   input  logic [PER_ADDR_WIDTH-1:0] per_slave_add_i,
   input  logic                      per_slave_wen_i,
   input  logic [31:0]               per_slave_wdata_i,
   input  logic [3:0]                per_slave_be_i,
   input  logic [PER_ID_WIDTH-1:0]   per_slave_id_i,
   output logic                      per_slave_gnt_o,

   output logic                      per_slave_r_valid_o,
   output logic                      per_slave_r_opc_o,
   output logic [PER_ID_WIDTH-1:0]   per_slave_r_id_o,
   output logic [31:0]               per_slave_r_rdata_o,

   output logic                      mem_req_o,
   output logic                      mem_we_o,
   output logic [ADDR_WIDTH-1:0]     mem_addr_o,
   output logic [31:0]               mem_wdata_o,
   output logic [3:0]                mem_be_o,
   input  logic [31:0]               mem_rdata_i,

   input  logic                      stats_clr_i,
   output logic [ADDR_WIDTH:0]       wr_count_o,
   output logic [31:0]               wr_xor_o,
   output logic                      err_o
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

   localparam logic [PER_ADDR_WIDTH-1:0] c_base = BASE_ADDR;

   state_t                    r_state;
   logic [PER_ID_WIDTH-1:0]   r_id;
   logic                      r_wen;
   logic                      r_err;

   logic [ADDR_WIDTH:0]       r_wr_count;
   logic [31:0]               r_wr_xor;
   logic                      r_err_sticky;

   logic [PER_ADDR_WIDTH-1:0] w_offset;
   logic                      w_below;
   logic                      w_above;
   logic                      w_misalign;
   logic                      w_err;
   logic                      w_gnt;
   logic                      w_wr_ok;
   logic                      w_valid;

   // ------------------------------------------------------------------------
   // Request decode
   // ------------------------------------------------------------------------
   assign w_offset   = per_slave_add_i - c_base;
   assign w_below    = (per_slave_add_i < c_base);
   // Any offset bit at or above the top of the SRAM byte range is out of range.
   assign w_above    = ((w_offset >> (ADDR_WIDTH + 2)) != '0);
   assign w_misalign = (per_slave_add_i[1:0] != 2'b00);
   assign w_err      = w_below | w_above | w_misalign;

   // Grant is forced low during reset so nothing is accepted in that cycle.
   assign w_gnt   = (r_state == IDLE) && per_slave_req_i && !rst_i;
   assign w_wr_ok = w_gnt && !w_err && !per_slave_wen_i;

   assign per_slave_gnt_o = w_gnt;

   // ------------------------------------------------------------------------
   // SRAM strobe: only in the accept cycle of an in-range request
   // ------------------------------------------------------------------------
   assign mem_req_o   = w_gnt && !w_err;
   assign mem_we_o    = mem_req_o && !per_slave_wen_i;
   assign mem_addr_o  = w_offset[ADDR_WIDTH+1:2];
   assign mem_wdata_o = per_slave_wdata_i;
   assign mem_be_o    = per_slave_be_i;

   // ------------------------------------------------------------------------
   // Response: SRAM read data arrives during RESP, so it is forwarded
   // straight through rather than registered.
   // ------------------------------------------------------------------------
   assign w_valid             = (r_state == RESP) && !rst_i;
   assign per_slave_r_valid_o = w_valid;
   assign per_slave_r_opc_o   = w_valid && r_err;
   assign per_slave_r_id_o    = w_valid ? r_id : '0;
   assign per_slave_r_rdata_o = (w_valid && !r_err && r_wen) ? mem_rdata_i : 32'h0;

   // ------------------------------------------------------------------------
   // Transaction FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_id    <= '0;
         r_wen   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_gnt) begin
                  r_id    <= per_slave_id_i;
                  r_wen   <= per_slave_wen_i;
                  r_err   <= w_err;
                  r_state <= RESP;
               end
            end
            RESP: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Statistics; clear wins over an event in the same cycle.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i || stats_clr_i) begin
         r_wr_count   <= '0;
         r_wr_xor     <= 32'h0;
         r_err_sticky <= 1'b0;
      end else begin
         if (w_wr_ok) begin
            if (~&r_wr_count) begin
               r_wr_count <= r_wr_count + 1'b1;
            end
            r_wr_xor <= r_wr_xor ^ per_slave_wdata_i;
         end
         if (w_gnt && w_err) begin
            r_err_sticky <= 1'b1;
         end
      end
   end

   assign wr_count_o = r_wr_count;
   assign wr_xor_o   = r_wr_xor;
   assign err_o      = r_err_sticky;

endmodule
`default_nettype wire
